// File: rtl/clk_sel_pkg.sv
// Shared definitions for the clock-select sequencer: FSM encodings and counter sizing.
package clk_sel_pkg;

  typedef enum logic [2:0] {
    S_CLK0  = 3'd0,
    S_PROBE = 3'd1,
    S_SW1   = 3'd2,
    S_CLK1  = 3'd3,
    S_SW0   = 3'd4
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_sel_ctrl_edge_mon.sv
// clk1 activity monitor: synchronizes the clk1 toggle, counts edges per window and
// reports whether the last completed window saw at least MIN_EDGES edges.
module clk_edge_mon
  import clk_sel_pkg::*;
#(
  parameter int WIN_CYCLES = 64,
  parameter int MIN_EDGES  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  input  logic clk1_tog_i,
  output logic win_end_o,
  output logic win_pass_o,
  output logic clk1_ok_o
);

  localparam int WW = cnt_w(WIN_CYCLES);
  localparam int EW = cnt_w(MIN_EDGES + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [EW-1:0] MIN_V    = EW'(MIN_EDGES);
  localparam logic [EW-1:0] MIN_M1   = EW'(MIN_EDGES - 1);

  logic s1_q, s2_q, s3_q;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic ok_q, ok_d;
  logic edge_seen;
  logic pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk1_tog_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_seen = s2_q ^ s3_q;
  // An edge landing on the wrap cycle still counts toward the closing window.
  assign pass = (edge_cnt_q >= MIN_V) || (edge_seen && (edge_cnt_q == MIN_M1));

  always_comb begin
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ok_d       = ok_q;
    if (clear_i) begin
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      ok_d       = 1'b0;
    end else if (enable_i) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        ok_d       = pass;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (edge_seen && (edge_cnt_q < MIN_V)) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ok_q       <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ok_q       <= ok_d;
    end
  end

  assign win_end_o  = enable_i && !clear_i && (win_cnt_q == WIN_LAST);
  assign win_pass_o = pass;
  assign clk1_ok_o  = ok_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Sequencer for the glitch-free clock switch select: probes clk1, switches, settles.
// Define CLK_SEL_LOSS_FALLBACK_EN to fall back to clk0 and flag a fault when clk1 dies.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int WIN_CYCLES    = 64,
  parameter int MIN_EDGES     = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_sel_i,
  input  logic       clk1_tog_i,
  input  logic       clr_fault_i,
  output logic       sel_o,
  output logic       active_sel_o,
  output logic       busy_o,
  output logic       clk1_ok_o,
  output logic       fault_o,
  output logic [2:0] dbg_state_o
);

  localparam int SW = cnt_w(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_e        state_q;
  logic [SW-1:0] settle_q;
  logic          sel_q, active_q, busy_q;
  logic          fault_q, fault_d;
  logic          mon_en, win_end, win_pass;
  logic          loss, fault_set;

  // Monitor runs only while probing or on clk1; everywhere else it is held cleared.
  assign mon_en = (state_q == S_PROBE) || (state_q == S_CLK1);

  clk_edge_mon #(
    .WIN_CYCLES (WIN_CYCLES),
    .MIN_EDGES  (MIN_EDGES)
  ) u_edge_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (!mon_en),
    .enable_i   (mon_en),
    .clk1_tog_i (clk1_tog_i),
    .win_end_o  (win_end),
    .win_pass_o (win_pass),
    .clk1_ok_o  (clk1_ok_o)
  );

`ifdef CLK_SEL_LOSS_FALLBACK_EN
  assign loss = win_end && !win_pass;
`else
  assign loss = 1'b0;
`endif

  assign fault_set = ((state_q == S_PROBE) && req_sel_i && win_end && !win_pass) ||
                     ((state_q == S_CLK1) && loss);

  // A new fault outranks a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (fault_set) begin
      fault_d = 1'b1;
    end else if (clr_fault_i) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CLK0;
      settle_q <= '0;
      sel_q    <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLK0: begin
          if (req_sel_i && !fault_q) begin
            state_q <= S_PROBE;
            busy_q  <= 1'b1;
          end
        end
        S_PROBE: begin
          if (!req_sel_i) begin
            state_q <= S_CLK0;
            busy_q  <= 1'b0;
          end else if (win_end) begin
            if (win_pass) begin
              state_q  <= S_SW1;
              sel_q    <= 1'b1;
              settle_q <= '0;
            end else begin
              state_q <= S_CLK0;
              busy_q  <= 1'b0;
            end
          end
        end
        S_SW1: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= S_CLK1;
            active_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_CLK1: begin
          if (!req_sel_i || loss) begin
            state_q  <= S_SW0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b1;
            settle_q <= '0;
          end
        end
        S_SW0: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= S_CLK0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_CLK0;
          settle_q <= '0;
          sel_q    <= 1'b0;
          active_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o        = sel_q;
  assign active_sel_o = active_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign dbg_state_o  = state_q;

endmodule
